// File: rtl/matrix_transpose_pkg.sv
// Shared types, defaults and helpers for the streaming matrix transposer.
package matrix_transpose_pkg;

    localparam int unsigned N_DEFAULT          = 8;
    localparam int unsigned DATA_WIDTH_DEFAULT = 64;
    localparam int unsigned IDX_W_DEFAULT      = $clog2(N_DEFAULT);

    typedef logic [DATA_WIDTH_DEFAULT-1:0] elem_t;
    typedef logic [IDX_W_DEFAULT-1:0]      idx_t;
    typedef logic                          bank_sel_t;

    // Index counter width for an N-entry dimension, never narrower than 1 bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mt_bank.sv
// One N x N element buffer: row-wide write port, row or column read port.
module mt_bank
    import matrix_transpose_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned N          = N_DEFAULT,
    parameter int unsigned IDX_W      = idx_width(N)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [N*DATA_WIDTH-1:0] wrow,
    input  logic [IDX_W-1:0]        ridx,
    input  logic                    col_mode,
    output logic [N*DATA_WIDTH-1:0] rvec
);

    // Storage holds whole rows; contents are don't-care until written.
    logic [N*DATA_WIDTH-1:0] mem [N];

    // Row write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wrow;
        end
    end

    // Read port: column ridx (element r from row r) or row ridx.
    always_comb begin
        rvec = '0;
        if (col_mode) begin
            for (int r = 0; r < int'(N); r++) begin
                rvec[r*DATA_WIDTH +: DATA_WIDTH] = mem[r][32'(ridx)*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            rvec = mem[ridx];
        end
    end

endmodule

// File: rtl/matrix_transpose_stream.sv
// Streaming ping-pong transposer: rows in, columns (or rows in pass mode) out.
module matrix_transpose_stream
    import matrix_transpose_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned N          = N_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_row,
    input  logic                    in_transpose,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*DATA_WIDTH-1:0] out_vec,
    output logic                    out_last
);

    localparam int unsigned IDX_W    = idx_width(N);
    localparam int unsigned VEC_W    = N * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    bank_sel_t        wr_bank;
    bank_sel_t        rd_bank;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic [1:0]       mode;
    logic             wr_fire;
    logic             rd_fire;
    logic [VEC_W-1:0] rvec0;
    logic [VEC_W-1:0] rvec1;

    // Handshakes depend only on registered flags, never on out_ready.
    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;

    // Full flags: completing a write and finishing a drain touch different banks.
    always_comb begin
        full_nxt = full;
        if (wr_fire && (wr_idx == LAST_IDX)) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_fire && (rd_idx == LAST_IDX)) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    // Bank pointers, index counters, full and mode flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            full    <= '0;
            mode    <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                if (wr_idx == '0) begin
                    mode[wr_bank] <= in_transpose;
                end
                if (wr_idx == LAST_IDX) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
            end
            if (rd_fire) begin
                if (rd_idx == LAST_IDX) begin
                    rd_idx  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_idx <= rd_idx + IDX_W'(1);
                end
            end
        end
    end

    mt_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .IDX_W      (IDX_W)
    ) u_bank0 (
        .clk      (clk),
        .we       (wr_fire && (wr_bank == 1'b0)),
        .widx     (wr_idx),
        .wrow     (in_row),
        .ridx     (rd_idx),
        .col_mode (mode[0]),
        .rvec     (rvec0)
    );

    mt_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .IDX_W      (IDX_W)
    ) u_bank1 (
        .clk      (clk),
        .we       (wr_fire && (wr_bank == 1'b1)),
        .widx     (wr_idx),
        .wrow     (in_row),
        .ridx     (rd_idx),
        .col_mode (mode[1]),
        .rvec     (rvec1)
    );

    // Output mux; zero whenever nothing is presented.
    assign out_vec  = out_valid ? (rd_bank ? rvec1 : rvec0) : '0;
    assign out_last = out_valid && (rd_idx == LAST_IDX);

endmodule

// File: tb/tb_matrix_transpose_stream.sv
// Scoreboard bench for matrix_transpose_stream (N=4, DATA_WIDTH=16).
module tb_matrix_transpose_stream;

    localparam int unsigned DW = 16;
    localparam int unsigned N  = 4;
    localparam int unsigned VW = N * DW;

    typedef struct packed {
        logic [VW-1:0] vec;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_row;
    logic          in_transpose;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_vec;
    logic          out_last;

    int nchecks   = 0;
    int nerrors   = 0;
    int rdy_pct   = 100;
    int cycle     = 0;
    int stall_cnt = 0;

    // Reference model state
    logic [DW-1:0] mrow [N][N];
    int            row_cnt = 0;
    logic          cur_mode = 1'b0;
    beat_t         sb_q[$];
    int            fire_cyc[$];

    matrix_transpose_stream #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_row       (in_row),
        .in_transpose (in_transpose),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_vec      (out_vec),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    task automatic chk(input string name, input logic [VW:0] act, input logic [VW:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: collect accepted rows, emit the expected beats once a matrix is complete.
    initial forever begin
        @(negedge clk);
        if (rst && in_valid && in_ready) begin
            if (row_cnt == 0) cur_mode = in_transpose;
            for (int c = 0; c < int'(N); c++) mrow[row_cnt][c] = in_row[c*DW +: DW];
            row_cnt++;
            if (row_cnt == int'(N)) begin
                for (int k = 0; k < int'(N); k++) begin
                    beat_t b;
                    for (int r = 0; r < int'(N); r++)
                        b.vec[r*DW +: DW] = cur_mode ? mrow[r][k] : mrow[k][r];
                    b.last = (k == int'(N) - 1);
                    sb_q.push_back(b);
                end
                row_cnt = 0;
            end
        end
    end

    // Monitor: compare every accepted output beat against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (!out_valid) chk("idle_out", {out_last, out_vec}, '0);
            if (out_valid && out_ready) begin
                fire_cyc.push_back(cycle);
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    chk("out_vec", out_vec, e.vec);
                    chk("out_last", out_last, e.last);
                end
            end
        end
    end

    // Downstream ready generator.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [VW-1:0] dir_row(input int r);
        logic [VW-1:0] v;
        for (int c = 0; c < int'(N); c++) v[c*DW +: DW] = {8'(r), 8'(c)};
        return v;
    endfunction

    // Present a row and hold it until accepted; entered and left at posedge+1.
    task automatic send_row(input logic [VW-1:0] row, input logic tr, input int vpct);
        int t;
        while ($urandom_range(99) >= vpct) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_row = row;
        in_transpose = tr;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stall_cnt++;
            t++;
            if (t > 300) begin
                chk("in_timeout", 1'b1, 1'b0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_matrix(input logic tr, input int vpct, input bit rnd);
        for (int r = 0; r < int'(N); r++) begin
            logic [VW-1:0] row;
            row = rnd ? {$urandom, $urandom} : dir_row(r);
            send_row(row, (r == 0) ? tr : 1'($urandom_range(1)), vpct);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 1'(sb_q.size() == 0), 1'b1);
    endtask

    // Async reset away from any edge; checks take effect with no clock.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_last", out_last, 1'b0);
        sb_q.delete();
        row_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_row = '0;
        in_transpose = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out", {out_last, out_vec}, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single transpose and its latency
        for (int r = 0; r < int'(N); r++) begin
            send_row(dir_row(r), (r == 0) ? 1'b1 : 1'b0, 100);
            if (r == int'(N) - 2) chk("latency_early", out_valid, 1'b0);
            if (r == int'(N) - 1) chk("latency_valid", out_valid, 1'b1);
        end
        wait_drain();

        // Pass mode
        send_matrix(1'b0, 100, 0);
        wait_drain();

        // Back-to-back, alternating mode, no bubbles either side
        fire_cyc.delete();
        stall_cnt = 0;
        for (int m = 0; m < 3; m++) send_matrix(1'(m % 2 == 0), 100, 0);
        wait_drain();
        chk("b2b_stalls", 32'(stall_cnt), 0);
        chk("b2b_beats", 32'(fire_cyc.size()), 12);
        if (fire_cyc.size() == 12) chk("b2b_span", 32'(fire_cyc[11] - fire_cyc[0]), 11);

        // Backpressure: both banks fill, output holds column 0
        rdy_pct = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send_matrix(1'b1, 100, 0);
        send_matrix(1'b0, 100, 0);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_col0", out_vec, 64'h0300_0200_0100_0000);
        in_valid = 1'b1;
        in_row = dir_row(0);
        in_transpose = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("bp_hold_ready", in_ready, 1'b0);
            chk("bp_hold_vec", out_vec, 64'h0300_0200_0100_0000);
        end
        @(posedge clk);
        #1;
        rdy_pct = 100;
        send_matrix(1'b1, 100, 0);
        wait_drain();

        // Random traffic
        rdy_pct = 50;
        for (int m = 0; m < 100; m++) send_matrix(1'($urandom_range(1)), 50, 1);
        rdy_pct = 100;
        wait_drain();

        // Reset mid-row-2
        send_row(dir_row(0), 1'b1, 100);
        send_row(dir_row(1), 1'b0, 100);
        in_valid = 1'b1;
        in_row = dir_row(2);
        do_reset();
        send_matrix(1'b1, 100, 1);
        wait_drain();

        // Reset mid-drain
        send_matrix(1'b1, 100, 1);
        @(posedge clk);
        #1;
        chk("mid_drain_valid", out_valid, 1'b1);
        do_reset();
        send_matrix(1'b0, 100, 1);
        wait_drain();
        send_matrix(1'b1, 100, 0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
